// File: rtl/flag_cond_unit.sv
// Flag register plus condition-code evaluator with same-cycle flag forwarding.
// Optional saturating request/pass counters are enabled by defining COND_STATS_EN.
module flag_cond_unit #(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [3:0]       flags_in,
  input  logic             req_valid,
  input  logic [3:0]       cond,
  input  logic             stall,
  input  logic             flush,
  output logic             resp_valid,
  output logic             cond_pass,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] eval_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  logic [3:0] flags_q;
  logic [3:0] fwd;
  logic       pass;
  logic       adv;

  // Stall and flush both freeze state; flush additionally drops resp_valid.
  assign adv = ~stall & ~flush;

  // A request in the same cycle as a flag write must see the new flags.
  assign fwd = flag_we ? flags_in : flags_q;

  function automatic logic eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: eval = z;
      4'b0001: eval = ~z;
      4'b0010: eval = cf;
      4'b0011: eval = ~cf;
      4'b0100: eval = n;
      4'b0101: eval = ~n;
      4'b0110: eval = v;
      4'b0111: eval = ~v;
      4'b1000: eval = cf & ~z;
      4'b1001: eval = ~cf | z;
      4'b1010: eval = (n == v);
      4'b1011: eval = (n != v);
      4'b1100: eval = ~z & (n == v);
      4'b1101: eval = z | (n != v);
      4'b1110: eval = 1'b1;
      default: eval = 1'b0;
    endcase
  endfunction

  assign pass = eval(cond, fwd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags_q <= FLAGS_RST;
    else if (adv && flag_we)
      flags_q <= flags_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      cond_pass  <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (!stall) begin
      resp_valid <= req_valid;
      if (req_valid)
        cond_pass <= pass;
    end
  end

  assign flags_out = flags_q;

`ifdef COND_STATS_EN
  logic take;
  assign take = adv & req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt <= '0;
      pass_cnt <= '0;
    end else if (take) begin
      if (eval_cnt != '1)
        eval_cnt <= eval_cnt + CNT_W'(1);
      if (pass && pass_cnt != '1)
        pass_cnt <= pass_cnt + CNT_W'(1);
    end
  end
`else
  assign eval_cnt = '0;
  assign pass_cnt = '0;
`endif

endmodule
